mem_bus_arbiter: RTL and testbench

Two-requester arbiter that shares one memory/peripheral bus between the instruction-fetch path (pc/im side) and the data path (load/store side). It grants one transaction at a time over a registered request/acknowledge handshake, with round-robin tie-breaking and a per-transaction timeout. It exposes a `stall` signal that freezes the pc while either requester is waiting. This block is what lets the core run on a single unified memory port instead of separate im and data memory.

---
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the arbiter and the shared memory bus.
// The arbiter takes the master view because it masters the shared bus.
interface mem_bus_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          i_err;

  logic          d_req;
  logic          d_wr;
  logic [2:0]    d_op;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          d_err;

  logic          m_req;
  logic          m_wr;
  logic [2:0]    m_op;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ack;

  logic          stall;

  modport master (
    input  i_req, i_addr, d_req, d_wr, d_op, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
    output m_req, m_wr, m_op, m_addr, m_wdata, stall
  );

  modport slave (
    output i_req, i_addr, d_req, d_wr, d_op, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
    input  m_req, m_wr, m_op, m_addr, m_wdata, stall
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the fetch and data paths, with a
// registered req/ack handshake and a per-transaction timeout.
module mem_bus_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [2:0]  IFETCH_OP = 3'd0
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;  // 1: data port was granted last
  logic [7:0]    cnt_q, cnt_d;
  logic          m_req_q, m_req_d;
  logic          m_wr_q, m_wr_d;
  logic [2:0]    m_op_q, m_op_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          i_err_q, i_err_d;
  logic          d_err_q, d_err_d;

  logic grant_d;
  logic timeout_hit;

  // Data wins unless fetch is also pending and data was served last.
  assign grant_d     = bus.d_req & (~bus.i_req | ~last_q);
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_wr_q    <= 1'b0;
      m_op_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_wr_q    <= m_wr_d;
      m_op_q    <= m_op_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d)        state_d = StBusyD;
        else if (bus.i_req) state_d = StBusyI;
      end
      StBusyI, StBusyD: begin
        if (bus.m_ack || timeout_hit) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_d    = last_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_wr_d    = m_wr_q;
    m_op_d    = m_op_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    // Acks and errors are single-cycle: only raised on the edge into StResp.
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    d_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          m_req_d   = 1'b1;
          m_wr_d    = bus.d_wr;
          m_op_d    = bus.d_op;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          last_d    = 1'b1;
          cnt_d     = '0;
        end else if (bus.i_req) begin
          m_req_d   = 1'b1;
          m_wr_d    = 1'b0;
          m_op_d    = IFETCH_OP;
          m_addr_d  = bus.i_addr;
          m_wdata_d = '0;
          last_d    = 1'b0;
          cnt_d     = '0;
        end
      end
      StBusyI: begin
        if (bus.m_ack) begin
          m_req_d   = 1'b0;
          i_rdata_d = bus.m_rdata;
          i_ack_d   = 1'b1;
        end else if (timeout_hit) begin
          m_req_d = 1'b0;
          i_ack_d = 1'b1;
          i_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StBusyD: begin
        if (bus.m_ack) begin
          m_req_d   = 1'b0;
          d_rdata_d = bus.m_rdata;
          d_ack_d   = 1'b1;
        end else if (timeout_hit) begin
          m_req_d = 1'b0;
          d_ack_d = 1'b1;
          d_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_wr    = m_wr_q;
  assign bus.m_op    = m_op_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.i_err   = i_err_q;
  assign bus.d_err   = d_err_q;
  assign bus.stall   = (bus.i_req & ~i_ack_q) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: tasks push expected grants/acks, monitors compare.
module tb_mem_bus_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic        wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } ack_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  mem_bus_arbiter_if #(.AW(AW), .DW(DW)) b ();
  mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bt ();

  mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(255), .IFETCH_OP(3'd0)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4), .IFETCH_OP(3'd0)) dut_to (
    .clk(clk), .rst(rst), .bus(bt)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] mem [logic [31:0]];
  grant_t g_exp_q[$];
  ack_t   i_exp_q[$];
  ack_t   d_exp_q[$];

  function automatic logic [31:0] bus_rdata(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5a5a_5a5a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic exp_grant(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata);
    grant_t g;
    g.wr = wr; g.op = op; g.addr = addr; g.wdata = wdata;
    g_exp_q.push_back(g);
  endtask

  // Bus responder for the main DUT: ack after ack_delay m_req cycles (0 = same cycle).
  int ack_delay = 0;
  int wait_cnt  = 0;
  bit stray     = 1'b0;
  initial begin
    b.m_ack = 1'b0;
    b.m_rdata = '0;
    forever begin
      @(negedge clk);
      if (b.m_req) begin
        b.m_ack = (wait_cnt == ack_delay);
        b.m_rdata = bus_rdata(b.m_addr);
        wait_cnt++;
      end else begin
        b.m_ack = stray;
        b.m_rdata = 32'hdead_beef;
        wait_cnt = 0;
      end
    end
  end

  bit bt_ack_en = 1'b1;
  initial begin
    bt.m_ack = 1'b0;
    bt.m_rdata = '0;
    forever begin
      @(negedge clk);
      bt.m_ack = bt.m_req & bt_ack_en;
      bt.m_rdata = bus_rdata(bt.m_addr);
    end
  end

  // Monitor: grants, payload stability, m_req length and acks.
  logic   prev_mreq = 1'b0;
  grant_t held;
  int     cur_len = 0, last_mreq_len = 0;
  int     i_ack_cyc = 0, d_ack_cyc = 0, i_acks = 0, d_acks = 0;
  initial forever begin
    grant_t g, cur;
    ack_t   e;
    @(negedge clk);
    cur.wr = b.m_wr; cur.op = b.m_op; cur.addr = b.m_addr; cur.wdata = b.m_wdata;
    if (b.m_req && !prev_mreq) begin
      if (g_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL grant_unexpected: got addr 0x%08h, required no grant", b.m_addr);
      end else begin
        g = g_exp_q.pop_front();
        check("grant_wr", {31'd0, b.m_wr}, {31'd0, g.wr});
        check("grant_op", {29'd0, b.m_op}, {29'd0, g.op});
        check("grant_addr", b.m_addr, g.addr);
        if (g.wr) check("grant_wdata", b.m_wdata, g.wdata);
      end
      held = cur;
    end else if (b.m_req && prev_mreq) begin
      checks++;
      if (cur !== held) begin
        errors++;
        $display("FAIL m_stable: got addr 0x%08h wdata 0x%08h, required addr 0x%08h wdata 0x%08h",
                 cur.addr, cur.wdata, held.addr, held.wdata);
      end
    end
    if (b.m_req) cur_len++;
    else if (prev_mreq) begin last_mreq_len = cur_len; cur_len = 0; end
    prev_mreq = b.m_req;

    if (b.i_ack || b.d_ack) begin
      checks++;
      if (b.i_ack && b.d_ack) begin
        errors++;
        $display("FAIL ack_exclusive: got i_ack=1 d_ack=1, required at most one");
      end
    end
    if (b.i_ack) begin
      i_ack_cyc = cyc; i_acks++;
      if (i_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL i_ack_unexpected: got i_ack, required none");
      end else begin
        e = i_exp_q.pop_front();
        check("i_err", {31'd0, b.i_err}, {31'd0, e.err});
        check("i_rdata", b.i_rdata, e.rdata);
      end
    end
    if (b.d_ack) begin
      d_ack_cyc = cyc; d_acks++;
      if (d_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL d_ack_unexpected: got d_ack, required none");
      end else begin
        e = d_exp_q.pop_front();
        check("d_err", {31'd0, b.d_err}, {31'd0, e.err});
        check("d_rdata", b.d_rdata, e.rdata);
      end
    end
  end

  task automatic do_i(input logic [31:0] addr, output int lat, output int stall_cnt,
                      output logic stall_ack);
    ack_t e;
    e.err = 1'b0; e.rdata = bus_rdata(addr);
    i_exp_q.push_back(e);
    b.i_req = 1'b1; b.i_addr = addr;
    lat = 0; stall_cnt = 0; stall_ack = 1'b0;
    for (int n = 1; n <= 500; n++) begin
      @(posedge clk); #1;
      if (b.i_ack) begin lat = n; stall_ack = b.stall; break; end
      if (b.stall) stall_cnt++;
    end
    if (lat == 0) fail_now("i_ack_wait");
    b.i_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_d(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, output int lat, output int stall_cnt,
                      output logic stall_ack);
    ack_t e;
    e.err = 1'b0; e.rdata = bus_rdata(addr);
    d_exp_q.push_back(e);
    b.d_req = 1'b1; b.d_wr = wr; b.d_op = op; b.d_addr = addr; b.d_wdata = wdata;
    lat = 0; stall_cnt = 0; stall_ack = 1'b0;
    for (int n = 1; n <= 500; n++) begin
      @(posedge clk); #1;
      if (b.d_ack) begin lat = n; stall_ack = b.stall; break; end
      if (b.stall) stall_cnt++;
    end
    if (lat == 0) fail_now("d_ack_wait");
    b.d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_bt(input logic [31:0] addr, output int mreq_cnt, output int lat);
    bt.i_req = 1'b1; bt.i_addr = addr;
    mreq_cnt = 0; lat = 0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (bt.i_ack) begin lat = n; break; end
      if (bt.m_req) mreq_cnt++;
    end
    if (lat == 0) fail_now("bt_ack_wait");
    bt.i_req = 1'b0;
  endtask

  initial begin
    int   lat, sc, l1, s1, l2, s2, ia, da, mc;
    logic sa, a1, a2;
    b.i_req = 0; b.i_addr = 0; b.d_req = 0; b.d_wr = 0; b.d_op = 0; b.d_addr = 0; b.d_wdata = 0;
    bt.i_req = 0; bt.i_addr = 0; bt.d_req = 0; bt.d_wr = 0; bt.d_op = 0; bt.d_addr = 0;
    bt.d_wdata = 0;
    mem[32'h0040_0000] = 32'h3c08_abcd;
    mem[32'h1003_0000] = 32'hffff_8000;

    repeat (3) @(posedge clk); #1;
    check("rst_m_req", {31'd0, b.m_req}, 32'd0);
    check("rst_m_addr", b.m_addr, 32'd0);
    check("rst_acks", {30'd0, b.i_ack, b.d_ack}, 32'd0);
    check("rst_rdata", b.i_rdata | b.d_rdata, 32'd0);
    check("rst_stall", {31'd0, b.stall}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single fetch, bus acks in the first m_req cycle.
    exp_grant(1'b0, 3'd0, 32'h0040_0000, 32'h0);
    do_i(32'h0040_0000, lat, sc, sa);
    check("fetch_lat", lat, 32'd2);
    check("fetch_stall_wait", sc, 32'd1);
    check("fetch_stall_ack", {31'd0, sa}, 32'd0);

    // Simultaneous requests: last granted was fetch, so data goes first.
    exp_grant(1'b1, 3'd2, 32'h1001_0004, 32'h55);
    exp_grant(1'b0, 3'd0, 32'h0040_0004, 32'h0);
    fork
      do_d(1'b1, 3'd2, 32'h1001_0004, 32'h55, l1, s1, a1);
      do_i(32'h0040_0004, l2, s2, a2);
    join
    check("conflict_ack_gap", i_ack_cyc - d_ack_cyc, 32'd3);

    // Continuous conflict: D, I, D, I ...
    ia = i_acks; da = d_acks;
    for (int k = 0; k < 4; k++) begin
      exp_grant(k[0], 3'(k), 32'h1002_0000 + 32'(4 * k), 32'ha000 + 32'(k));
      exp_grant(1'b0, 3'd0, 32'h0040_0100 + 32'(4 * k), 32'h0);
    end
    fork
      for (int k = 0; k < 4; k++)
        do_d(k[0], 3'(k), 32'h1002_0000 + 32'(4 * k), 32'ha000 + 32'(k), l1, s1, a1);
      for (int j = 0; j < 4; j++)
        do_i(32'h0040_0100 + 32'(4 * j), l2, s2, a2);
    join
    check("cont_i_acks", i_acks - ia, 32'd4);
    check("cont_d_acks", d_acks - da, 32'd4);
    check("cont_grants_left", g_exp_q.size(), 32'd0);

    // Wait states: bus acks 5 cycles late.
    ack_delay = 5;
    exp_grant(1'b0, 3'd1, 32'h1003_0000, 32'h0);
    do_d(1'b0, 3'd1, 32'h1003_0000, 32'h0, lat, sc, sa);
    check("wait_lat", lat, 32'd7);
    check("wait_stall", sc, 32'd6);
    check("wait_stall_ack", {31'd0, sa}, 32'd0);
    check("wait_mreq_len", last_mreq_len, 32'd6);
    ack_delay = 0;

    // Stray m_ack outside BUSY must be ignored.
    ia = i_acks; da = d_acks;
    stray = 1'b1;
    repeat (4) @(posedge clk); #1;
    stray = 1'b0;
    @(posedge clk); #1;
    check("stray_acks", (i_acks - ia) + (d_acks - da), 32'd0);

    // Reset in the middle of a data transaction.
    ack_delay = 1000;
    exp_grant(1'b1, 3'd4, 32'h1004_0000, 32'h1234);
    b.d_req = 1'b1; b.d_wr = 1'b1; b.d_op = 3'd4; b.d_addr = 32'h1004_0000; b.d_wdata = 32'h1234;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (b.m_req) break;
    end
    if (!b.m_req) fail_now("rst_mid_grant");
    @(posedge clk); #2;
    da = d_acks;
    rst = 1'b0;
    #1;
    check("rstmid_m_req", {31'd0, b.m_req}, 32'd0);
    check("rstmid_m_addr", b.m_addr, 32'd0);
    check("rstmid_m_wdata", b.m_wdata, 32'd0);
    check("rstmid_i_rdata", b.i_rdata, 32'd0);
    check("rstmid_d_ack", {31'd0, b.d_ack}, 32'd0);
    b.d_req = 1'b0;
    ack_delay = 0;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_no_ack", d_acks - da, 32'd0);
    exp_grant(1'b0, 3'd0, 32'h1005_0000, 32'h0);
    exp_grant(1'b0, 3'd0, 32'h0040_0200, 32'h0);
    fork
      do_d(1'b0, 3'd0, 32'h1005_0000, 32'h0, l1, s1, a1);
      do_i(32'h0040_0200, l2, s2, a2);
    join
    check("rstmid_d_first_gap", i_ack_cyc - d_ack_cyc, 32'd3);

    // Timeout instance (TIMEOUT = 4).
    bt_ack_en = 1'b1;
    do_bt(32'h100, mc, lat);
    check("bt_ok_err", {31'd0, bt.i_err}, 32'd0);
    check("bt_ok_rdata", bt.i_rdata, bus_rdata(32'h100));
    @(posedge clk); #1;
    bt_ack_en = 1'b0;
    do_bt(32'h200, mc, lat);
    check("to_mreq_cycles", mc, 32'd4);
    check("to_lat", lat, 32'd5);
    check("to_err", {31'd0, bt.i_err}, 32'd1);
    check("to_rdata_kept", bt.i_rdata, bus_rdata(32'h100));
    @(posedge clk); #1;
    check("to_ack_pulse", {31'd0, bt.i_ack}, 32'd0);
    check("to_err_clear", {31'd0, bt.i_err}, 32'd0);
    bt_ack_en = 1'b1;
    do_bt(32'h300, mc, lat);
    check("after_to_err", {31'd0, bt.i_err}, 32'd0);
    check("after_to_rdata", bt.i_rdata, bus_rdata(32'h300));
    check("after_to_lat", lat, 32'd2);

    repeat (3) @(posedge clk); #1;
    check("left_grants", g_exp_q.size(), 32'd0);
    check("left_i_acks", i_exp_q.size(), 32'd0);
    check("left_d_acks", d_exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
